// File: rtl/fp_pkg.sv
// Shared types for the floating-point max finder: sample format and FSM states.
package fp_pkg;

    localparam int unsigned EXP_W  = 4;
    localparam int unsigned FRAC_W = 8;

    // Sign-magnitude sample; frac is normalized (MSB = 1).
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

endpackage

// File: rtl/greaterthan.sv
// Combinational strict greater-than for sign-magnitude fp_t samples (a > b).
module greaterthan
    import fp_pkg::*;
(
    input  fp_t  a,
    input  fp_t  b,
    output logic gt
);

    logic [EXP_W+FRAC_W-1:0] mag_a;
    logic [EXP_W+FRAC_W-1:0] mag_b;

    assign mag_a = {a.exp, a.frac};
    assign mag_b = {b.exp, b.frac};

    // Positive beats negative; among negatives the larger magnitude is the smaller value.
    always_comb begin
        gt = 1'b0;
        if (a.sign != b.sign) begin
            gt = ~a.sign;
        end else if (!a.sign) begin
            gt = (mag_a > mag_b);
        end else begin
            gt = (mag_a < mag_b);
        end
    end

endmodule

// File: rtl/fp_max_finder.sv
// Streams samples of a frame and reports the maximum, its index and the frame length.
// A frame ends on in_last or when the count reaches 2^IDX_W (reported as truncated).
module fp_max_finder
    import fp_pkg::*;
#(
    parameter int unsigned IDX_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W-1:0] in_frac,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic [IDX_W-1:0]  out_index,
    output logic [IDX_W:0]    out_count,
    output logic              out_trunc
);

    localparam logic [IDX_W:0] CountMax = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0] CountOne = {{IDX_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    fp_t               max_q, max_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [IDX_W:0]    count_q, count_d;
    logic              trunc_q, trunc_d;
    logic              valid_q, valid_d;

    fp_t               sample;
    logic              take;
    logic              sample_gt;
    logic [IDX_W:0]    count_inc;

    assign sample    = {in_sign, in_exp, in_frac};
    assign in_ready  = (state_q != StDone);
    assign take      = in_valid & in_ready;
    assign count_inc = count_q + CountOne;

    greaterthan u_greaterthan (
        .a  (sample),
        .b  (max_q),
        .gt (sample_gt)
    );

    // Next-state: load on first sample, update on strictly greater, close on last or count limit.
    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        index_d = index_q;
        count_d = count_q;
        trunc_d = trunc_q;
        unique case (state_q)
            StIdle: begin
                if (take) begin
                    max_d   = sample;
                    index_d = '0;
                    count_d = CountOne;
                    trunc_d = 1'b0;
                    state_d = in_last ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (take) begin
                    if (sample_gt) begin
                        max_d   = sample;
                        index_d = count_q[IDX_W-1:0];
                    end
                    count_d = count_inc;
                    if (in_last) begin
                        state_d = StDone;
                    end else if (count_inc == CountMax) begin
                        trunc_d = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        valid_d = (state_d == StDone);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            max_q   <= '0;
            index_q <= '0;
            count_q <= '0;
            trunc_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            index_q <= index_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sign  = max_q.sign;
    assign out_exp   = max_q.exp;
    assign out_frac  = max_q.frac;
    assign out_index = index_q;
    assign out_count = count_q;
    assign out_trunc = trunc_q;

endmodule

// File: tb/tb_fp_max_finder.sv
// Directed bench: a default-width instance for frame tests and an IDX_W = 2 instance for truncation.
module tb_fp_max_finder;

    logic clk = 1'b0;
    logic reset;
    logic iv;
    logic orv;
    bit   sel;

    logic       in_sign;
    logic [3:0] in_exp;
    logic [7:0] in_frac;
    logic       in_last;

    logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_sign, m_out_trunc;
    logic [3:0] m_out_exp;
    logic [7:0] m_out_frac;
    logic [7:0] m_out_index;
    logic [8:0] m_out_count;

    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sign, s_out_trunc;
    logic [3:0] s_out_exp;
    logic [7:0] s_out_frac;
    logic [1:0] s_out_index;
    logic [2:0] s_out_count;

    logic       c_in_ready, c_out_valid, c_out_sign, c_out_trunc;
    logic [3:0] c_out_exp;
    logic [7:0] c_out_frac;
    logic [7:0] c_out_index;
    logic [8:0] c_out_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign m_in_valid  = iv & ~sel;
    assign s_in_valid  = iv & sel;
    assign m_out_ready = orv & ~sel;
    assign s_out_ready = orv & sel;

    assign c_in_ready  = sel ? s_in_ready  : m_in_ready;
    assign c_out_valid = sel ? s_out_valid : m_out_valid;
    assign c_out_sign  = sel ? s_out_sign  : m_out_sign;
    assign c_out_trunc = sel ? s_out_trunc : m_out_trunc;
    assign c_out_exp   = sel ? s_out_exp   : m_out_exp;
    assign c_out_frac  = sel ? s_out_frac  : m_out_frac;
    assign c_out_index = sel ? {6'b0, s_out_index} : m_out_index;
    assign c_out_count = sel ? {6'b0, s_out_count} : m_out_count;

    fp_max_finder #(.IDX_W(8)) u_main (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (m_in_valid),
        .in_ready  (m_in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_frac   (in_frac),
        .in_last   (in_last),
        .out_valid (m_out_valid),
        .out_ready (m_out_ready),
        .out_sign  (m_out_sign),
        .out_exp   (m_out_exp),
        .out_frac  (m_out_frac),
        .out_index (m_out_index),
        .out_count (m_out_count),
        .out_trunc (m_out_trunc)
    );

    fp_max_finder #(.IDX_W(2)) u_small (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_frac   (in_frac),
        .in_last   (in_last),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_sign  (s_out_sign),
        .out_exp   (s_out_exp),
        .out_frac  (s_out_frac),
        .out_index (s_out_index),
        .out_count (s_out_count),
        .out_trunc (s_out_trunc)
    );

    // Samples packed as {sign, exp[3:0], frac[7:0]}.
    typedef struct {
        logic [12:0] s [4];
        int          n;
        logic [12:0] mx;
        int          idx;
        int          cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_result(input string tag, input logic [12:0] mx, input int idx,
                                input int cnt, input bit trunc);
        check({tag, " out_valid"}, 32'(c_out_valid), 32'd1);
        check({tag, " sign"},      32'(c_out_sign),  32'(mx[12]));
        check({tag, " exp"},       32'(c_out_exp),   32'(mx[11:8]));
        check({tag, " frac"},      32'(c_out_frac),  32'(mx[7:0]));
        check({tag, " index"},     32'(c_out_index), 32'(idx));
        check({tag, " count"},     32'(c_out_count), 32'(cnt));
        check({tag, " trunc"},     32'(c_out_trunc), 32'(trunc));
    endtask

    // Offer one sample for one cycle; called and returns at a falling edge.
    task automatic put(input logic [12:0] s, input bit last);
        {in_sign, in_exp, in_frac} = s;
        in_last = last;
        iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic release_result(input string tag);
        orv = 1'b1;
        @(negedge clk);
        orv = 1'b0;
        check({tag, " valid cleared"}, 32'(c_out_valid), 32'd0);
        check({tag, " ready again"},   32'(c_in_ready),  32'd1);
    endtask

    task automatic run_vec(input int k);
        string tag;
        tag = $sformatf("vec%0d", k);
        for (int i = 0; i < vecs[k].n; i++) begin
            check({tag, " in_ready"},    32'(c_in_ready),  32'd1);
            check({tag, " early valid"}, 32'(c_out_valid), 32'd0);
            put(vecs[k].s[i], (i == vecs[k].n - 1));
        end
        check_result(tag, vecs[k].mx, vecs[k].idx, vecs[k].cnt, 1'b0);
    endtask

    initial begin
        vecs[0] = '{'{13'h0880, 13'h0980, 13'h08C0, 13'h0}, 3, 13'h0980, 1, 3};
        vecs[1] = '{'{13'h1980, 13'h1880, 13'h0, 13'h0}, 2, 13'h1880, 1, 2};
        vecs[2] = '{'{13'h09C0, 13'h09C0, 13'h0, 13'h0}, 2, 13'h09C0, 0, 2};
        vecs[3] = '{'{13'h1A80, 13'h0180, 13'h0, 13'h0}, 2, 13'h0180, 1, 2};
        vecs[4] = '{'{13'h05A0, 13'h0, 13'h0, 13'h0}, 1, 13'h05A0, 0, 1};
        vecs[5] = '{'{13'h07F0, 13'h07F8, 13'h07F4, 13'h07F8}, 4, 13'h07F8, 1, 4};
        vecs[6] = '{'{13'h1380, 13'h1390, 13'h12FF, 13'h0}, 3, 13'h12FF, 2, 3};

        sel = 1'b0;
        iv = 1'b0;
        orv = 1'b0;
        in_last = 1'b0;
        {in_sign, in_exp, in_frac} = 13'h0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("reset in_ready",  32'(m_in_ready),  32'd1);
        check("reset out_valid", 32'(m_out_valid), 32'd0);
        check("reset fields",    32'({m_out_sign, m_out_exp, m_out_frac}), 32'd0);
        check("reset index",     32'(m_out_index), 32'd0);
        check("reset count",     32'(m_out_count), 32'd0);
        check("reset trunc",     32'(m_out_trunc), 32'd0);
        check("reset small",     32'({s_out_valid, s_out_count, s_in_ready}), 32'd1);

        // Hold in DONE for 10 cycles with samples offered; result must not move.
        run_vec(0);
        {in_sign, in_exp, in_frac} = 13'h0F80;
        iv = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold in_ready", 32'(c_in_ready), 32'd0);
            check("hold result",
                  32'({c_out_valid, c_out_sign, c_out_exp, c_out_frac, c_out_index[3:0]}),
                  32'({1'b1, 13'h0980, 4'd1}));
            check("hold count", 32'(c_out_count), 32'd3);
        end
        orv = 1'b1;
        @(negedge clk);
        orv = 1'b0;
        iv = 1'b0;
        check("hold exit valid", 32'(c_out_valid), 32'd0);
        check("hold exit ready", 32'(c_in_ready),  32'd1);

        for (int k = 0; k < 7; k++) begin
            run_vec(k);
            release_result($sformatf("vec%0d", k));
        end

        // Reset mid-frame, overriding a simultaneous last-sample transfer.
        put(13'h0980, 1'b0);
        put(13'h0A80, 1'b0);
        reset = 1'b1;
        {in_sign, in_exp, in_frac} = 13'h0B80;
        in_last = 1'b1;
        iv = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        iv = 1'b0;
        in_last = 1'b0;
        check("midreset in_ready",  32'(c_in_ready),  32'd1);
        check("midreset out_valid", 32'(c_out_valid), 32'd0);
        check("midreset count",     32'(c_out_count), 32'd0);
        check("midreset exp",       32'(c_out_exp),   32'd0);
        put(13'h1AA0, 1'b1);
        check_result("midreset -5.0", 13'h1AA0, 0, 1, 1'b0);
        release_result("midreset");

        // Count-limit close on the IDX_W = 2 instance.
        sel = 1'b1;
        put(13'h0880, 1'b0);
        put(13'h0980, 1'b0);
        put(13'h08C0, 1'b0);
        check("trunc early valid", 32'(c_out_valid), 32'd0);
        put(13'h09A0, 1'b0);
        check_result("trunc frame", 13'h09A0, 3, 4, 1'b1);
        check("trunc in_ready", 32'(c_in_ready), 32'd0);
        release_result("trunc");
        put(13'h0280, 1'b0);
        put(13'h1480, 1'b1);
        check_result("post-trunc frame", 13'h0280, 0, 2, 1'b0);
        release_result("post-trunc");
        sel = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
